// File: rtl/ascii_to_bin_4digits.sv
// Parses up to MAX_DIGITS ASCII decimal digits (MSD first) into an unsigned binary value.
// A CR, space or NUL terminates early; any other non-digit flags an error.
module ascii_to_bin_4digits #(
    parameter int unsigned MAX_DIGITS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        char_valid,
    input  logic [7:0]  char_in,
    output logic        char_ready,
    output logic [13:0] bin_out,
    output logic [2:0]  digit_count,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [1:0] {StIdle, StAccum, StFinish} state_e;

    localparam logic [2:0] MaxCnt = 3'(MAX_DIGITS);

    state_e      state_q, state_d;
    logic [13:0] acc_q, acc_d;
    logic [13:0] bin_q, bin_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        err_q, err_d;

    logic        is_digit;
    logic        is_term;
    logic [13:0] acc_next;
    logic [2:0]  cnt_inc;

    assign is_digit = (char_in >= 8'h30) && (char_in <= 8'h39);
    assign is_term  = (char_in == 8'h0D) || (char_in == 8'h20) || (char_in == 8'h00);
    // acc never exceeds 999 when a digit is accepted, so 14 bits cannot overflow.
    assign acc_next = (acc_q << 3) + (acc_q << 1) + {10'b0, char_in[3:0]};
    assign cnt_inc  = cnt_q + 3'd1;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        bin_d   = bin_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = StAccum;
                end
            end
            StAccum: begin
                if (char_valid) begin
                    state_d = StFinish;
                    if (is_digit) begin
                        acc_d = acc_next;
                        cnt_d = cnt_inc;
                        if (cnt_inc == MaxCnt) begin
                            bin_d = acc_next;
                            err_d = 1'b0;
                        end else begin
                            state_d = StAccum;
                        end
                    end else if (is_term && (cnt_q != 3'd0)) begin
                        bin_d = acc_q;
                        err_d = 1'b0;
                    end else begin
                        bin_d = '0;
                        err_d = 1'b1;
                    end
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            acc_q   <= '0;
            bin_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            bin_q   <= bin_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign char_ready  = (state_q == StAccum);
    assign done        = (state_q == StFinish);
    assign busy        = (state_q == StAccum) || (state_q == StFinish);
    assign bin_out     = bin_q;
    assign digit_count = cnt_q;
    assign error       = err_q;

endmodule

// File: tb/tb_ascii_to_bin_4digits.sv
// Bench for ascii_to_bin_4digits: directed and random parses checked against a string-level model.
// Two instances: default MAX_DIGITS=4 and MAX_DIGITS=2, selected by sel.
module tb_ascii_to_bin_4digits;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       sel;
    logic       s_start, s_valid;
    logic [7:0] s_in;

    logic        start0, valid0, start2, valid2;
    logic        r0, bs0, d0, e0, r2, bs2, d2, e2;
    logic [13:0] b0, b2;
    logic [2:0]  c0, c2;

    logic        o_ready, o_busy, o_done, o_err;
    logic [13:0] o_bin;
    logic [2:0]  o_cnt;

    assign start0 = s_start & ~sel;
    assign valid0 = s_valid & ~sel;
    assign start2 = s_start & sel;
    assign valid2 = s_valid & sel;

    assign o_ready = sel ? r2  : r0;
    assign o_busy  = sel ? bs2 : bs0;
    assign o_done  = sel ? d2  : d0;
    assign o_err   = sel ? e2  : e0;
    assign o_bin   = sel ? b2  : b0;
    assign o_cnt   = sel ? c2  : c0;

    ascii_to_bin_4digits dut4 (
        .clk(clk), .reset(reset), .start(start0), .char_valid(valid0), .char_in(s_in),
        .char_ready(r0), .bin_out(b0), .digit_count(c0), .busy(bs0), .done(d0), .error(e0)
    );

    ascii_to_bin_4digits #(.MAX_DIGITS(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .char_valid(valid2), .char_in(s_in),
        .char_ready(r2), .bin_out(b2), .digit_count(c2), .busy(bs2), .done(d2), .error(e2)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Parse a character string as the spec describes: value, digits, error, chars consumed.
    function automatic void model(input logic [7:0] c[$], input int maxd, output int val,
                                  output int cnt, output int err, output int used);
        val  = 0;
        cnt  = 0;
        err  = 0;
        used = c.size();
        for (int i = 0; i < c.size(); i++) begin
            if (c[i] >= 8'h30 && c[i] <= 8'h39) begin
                val = val * 10 + int'(c[i] - 8'h30);
                cnt++;
                if (cnt == maxd) begin
                    used = i + 1;
                    return;
                end
            end else begin
                used = i + 1;
                if (!(c[i] == 8'h0D || c[i] == 8'h20 || c[i] == 8'h00) || cnt == 0) begin
                    err = 1;
                    val = 0;
                end
                return;
            end
        end
    endfunction

    task automatic set_q(input string s);
        q.delete();
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    endtask

    task automatic run_parse(input logic [7:0] c[$], input int maxd, input int glo, input int ghi,
                             input bit start_at_done);
        int val, cnt, err, used, g;
        model(c, maxd, val, cnt, err, used);
        @(negedge clk);
        s_start = 1'b1;
        s_valid = 1'b0;
        @(negedge clk);
        s_start = 1'b0;
        chk("start_busy", 32'(o_busy), 1);
        chk("start_ready", 32'(o_ready), 1);
        chk("start_cnt", 32'(o_cnt), 0);
        chk("start_err", 32'(o_err), 0);
        for (int i = 0; i < used; i++) begin
            g = int'($urandom_range(ghi, glo));
            repeat (g) begin
                s_valid = 1'b0;
                s_in    = 8'($urandom);
                s_start = 1'($urandom_range(1, 0));
                @(negedge clk);
                chk("gap_done", 32'(o_done), 0);
                chk("gap_cnt", 32'(o_cnt), 32'(i));
            end
            s_valid = 1'b1;
            s_in    = c[i];
            s_start = 1'($urandom_range(1, 0));
            @(negedge clk);
            s_valid = 1'b0;
            s_start = 1'b0;
            if (i < used - 1) begin
                chk("mid_done", 32'(o_done), 0);
                chk("mid_cnt", 32'(o_cnt), 32'(i + 1));
            end
        end
        chk("fin_done", 32'(o_done), 1);
        chk("fin_ready", 32'(o_ready), 0);
        chk("fin_busy", 32'(o_busy), 1);
        chk("fin_bin", 32'(o_bin), 32'(val));
        chk("fin_cnt", 32'(o_cnt), 32'(cnt));
        chk("fin_err", 32'(o_err), 32'(err));
        s_start = start_at_done;
        @(negedge clk);
        chk("idle_done", 32'(o_done), 0);
        chk("idle_busy", 32'(o_busy), 0);
        chk("idle_ready", 32'(o_ready), 0);
        chk("idle_bin", 32'(o_bin), 32'(val));
        chk("idle_cnt", 32'(o_cnt), 32'(cnt));
        chk("idle_err", 32'(o_err), 32'(err));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_bin"}, 32'(o_bin), 0);
        chk({tag, "_cnt"}, 32'(o_cnt), 0);
        chk({tag, "_busy"}, 32'(o_busy), 0);
        chk({tag, "_done"}, 32'(o_done), 0);
        chk({tag, "_err"}, 32'(o_err), 0);
        chk({tag, "_ready"}, 32'(o_ready), 0);
    endtask

    initial begin
        int len, r;
        reset   = 1'b1;
        sel     = 1'b0;
        s_start = 1'b0;
        s_valid = 1'b0;
        s_in    = 8'h00;
        #1;
        chk_reset_vals("rst4");
        sel = 1'b1;
        #1;
        chk_reset_vals("rst2");
        sel = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        set_q("1234");
        run_parse(q, 4, 0, 0, 1'b0);
        set_q("42\r");
        run_parse(q, 4, 0, 0, 1'b0);
        set_q("9999");
        run_parse(q, 4, 0, 1, 1'b0);

        // Asynchronous reset in the middle of a parse, away from any clock edge.
        @(negedge clk);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        s_valid = 1'b1;
        s_in    = "1";
        @(negedge clk);
        s_in = "2";
        @(negedge clk);
        s_valid = 1'b0;
        chk("pre_rst_cnt", 32'(o_cnt), 2);
        #2 reset = 1'b1;
        #1;
        chk_reset_vals("async");
        @(negedge clk);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_done", 32'(o_done), 0);
            chk("post_rst_busy", 32'(o_busy), 0);
        end
        set_q("0007");
        run_parse(q, 4, 0, 0, 1'b0);

        set_q(" ");
        run_parse(q, 4, 0, 0, 1'b0);
        set_q("7A");
        run_parse(q, 4, 0, 0, 1'b0);
        set_q("5");
        q.push_back("6");
        q.push_back(8'h00);
        run_parse(q, 4, 3, 3, 1'b0);

        // Start held during the done cycle is ignored, then honoured from IDLE.
        set_q("31\r");
        run_parse(q, 4, 0, 0, 1'b1);
        @(negedge clk);
        s_start = 1'b0;
        chk("late_start_busy", 32'(o_busy), 1);
        s_valid = 1'b1;
        s_in    = 8'h0D;
        @(negedge clk);
        s_valid = 1'b0;
        chk("empty_done", 32'(o_done), 1);
        chk("empty_err", 32'(o_err), 1);
        chk("empty_cnt", 32'(o_cnt), 0);
        chk("empty_bin", 32'(o_bin), 0);

        for (int pass = 0; pass < 2; pass++) begin
            sel = (pass == 1);
            repeat (pass == 0 ? 40 : 12) begin
                q.delete();
                len = int'($urandom_range(5, 1));
                for (int k = 0; k < len; k++) begin
                    r = int'($urandom_range(9, 0));
                    if (r < 7)       q.push_back(8'(8'h30 + $urandom_range(9, 0)));
                    else if (r == 7) q.push_back((k % 3 == 0) ? 8'h0D : (k % 3 == 1) ? 8'h20 : 8'h00);
                    else             q.push_back(8'($urandom));
                end
                q.push_back(8'h20);
                run_parse(q, pass == 0 ? 4 : 2, 0, 2, 1'b0);
            end
        end

        sel = 1'b1;
        set_q("83");
        run_parse(q, 2, 0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ascii_to_bin_4digits.md
ASCII_TO_BIN_4DIGITS -- requirements
Module: ascii_to_bin_4digits

Interface
REQ-001 Parameter MAX_DIGITS, default 4, meaning maximum accepted decimal digits; legal range 1..4, so the result always fits 14 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  begin a new parse; sampled only in IDLE.
REQ-005 char_valid  input  1  char_in holds a character this cycle.
REQ-006 char_in  input  8  ASCII character, most-significant digit first.
REQ-007 char_ready  output  1  block accepts char_in this cycle.
REQ-008 bin_out  output  14  parsed unsigned binary value.
REQ-009 digit_count  output  3  digits accepted in the current or last parse.
REQ-010 busy  output  1  parse in progress (state ACCUM or FINISH).
REQ-011 done  output  1  one-cycle pulse: parse finished; bin_out/error valid.
REQ-012 error  output  1  last parse was malformed; level, valid from done onward.

Function
REQ-013 FSM states: IDLE, ACCUM, FINISH; encoding is free.
REQ-014 IDLE: start=1 -> clear accumulator, digit_count, error; next state ACCUM; start=0 -> stay IDLE.
REQ-015 start asserted in ACCUM or FINISH shall be ignored.
REQ-016 char_ready shall be 1 only in ACCUM; a character is accepted on a rising edge with char_valid=1 and char_ready=1.
REQ-017 char_valid while char_ready=0 shall have no effect; no character is buffered.
REQ-018 Digit = 0x30..0x39; on acceptance, acc <= acc*10 + (char_in - 0x30), digit_count <= digit_count + 1.
REQ-019 acc*10 shall be formed as (acc<<3)+(acc<<1) in at least 14 bits; no multiplier required.
REQ-020 Acceptance of the MAX_DIGITS-th digit shall move to FINISH with error=0; no terminator needed.
REQ-021 Terminator = 0x0D, 0x20 or 0x00; accepted terminator with digit_count>=1 -> FINISH, error=0.
REQ-022 Accepted terminator with digit_count=0 -> FINISH, error=1.
REQ-023 Any other accepted character -> FINISH, error=1.
REQ-024 On error, bin_out shall be 0; digit_count keeps the digits accepted before the bad character.
REQ-025 On success, bin_out shall equal the accumulator; leading zeros are legal ("0042" -> 42).
REQ-026 FINISH lasts exactly one cycle with done=1, then IDLE; done shall be 0 in all other states.
REQ-027 Latency: done is high in the cycle immediately after the edge that accepted the final character.
REQ-028 bin_out, digit_count and error shall hold their values in IDLE until the next accepted start.
REQ-029 bin_out shall not show partial accumulator values during ACCUM; it updates only on entry to FINISH.
REQ-030 start in the same cycle that done is high shall be ignored; it is honoured from the following IDLE cycle.

Reset
REQ-031 reset=1 shall force IDLE immediately, independent of clk.
REQ-032 Reset values: bin_out=0, digit_count=0, busy=0, done=0, error=0, char_ready=0, accumulator=0.
REQ-033 Reset during ACCUM or FINISH shall abort the parse with no done pulse after release.
REQ-034 After reset deassertion, the first start is honoured on the first rising edge.

Verification
REQ-035 start, then "1","2","3","4" on consecutive cycles -> done one cycle after the "4" edge, bin_out=1234, digit_count=4, error=0.
REQ-036 start, "4","2",0x0D -> bin_out=42, digit_count=2, error=0; then "9","9","9","9" -> bin_out=9999.
REQ-037 start, 0x20 as first character -> done, error=1, bin_out=0, digit_count=0; start, "7","A" -> error=1, digit_count=1, bin_out=0.
REQ-038 start, "5", char_valid low 3 cycles, then "6", 0x00 -> bin_out=56; no acceptance during gaps; start pulses during ACCUM ignored.
REQ-039 reset asserted mid-edge-asynchronously after "1","2" -> all outputs at reset values at once; no done after release; new parse "0","0","0","7" -> bin_out=7.
REQ-040 MAX_DIGITS=2: start, "8","3" -> done with bin_out=83 without terminator; char_ready=0 while done=1 and in IDLE.
